qab_sweep_ctrl: RTL and testbench
=================================

Name: qab_sweep_ctrl

Overview:
Sequencer that drives a 3-input combinational function-under-test (inputs A, B, C; output Q) through all 8 input vectors. For each vector it waits a programmable settle interval, samples Q, and compares it against an expected truth table. It reports the captured truth table, a per-vector mismatch mask and a pass flag. It sits between a lab control interface (start/abort) and the combinational block, replacing hand-timed stimulus.

Parameters:
SETTLE_W, 8, width of settle_len and of the settle counter
DEF_SETTLE, 4, settle length used when settle_len is 0

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  cancel sweep; returns to IDLE without done
settle_len  input  SETTLE_W  settle cycles per vector; latched at start
exp_tt  input  8  expected Q per vector index; latched at start
q_in  input  1  Q from the function-under-test
a_out  output  1  stimulus A (vector index bit 2)
b_out  output  1  stimulus B (vector index bit 1)
c_out  output  1  stimulus C (vector index bit 0)
vec_idx  output  3  current vector index
busy  output  1  high from the cycle after start acceptance through the DONE state
done  output  1  one-cycle pulse when the sweep completes
pass  output  1  sweep result; valid while done is high and held until the next start
cap_tt  output  8  captured Q per vector index
fail_mask  output  8  bit i = cap_tt[i] != expected[i]

Behaviour:
- Reset (async, rst_n low): state IDLE; a_out/b_out/c_out = 0, vec_idx = 0, busy = 0, done = 0, pass = 0, cap_tt = 0, fail_mask = 0, settle counter = 0. This applies immediately, including mid-sweep.
- All outputs are registered. {a_out, b_out, c_out} = vec_idx at all times.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - start = 1 latches exp_tt and settle_len into internal registers (settle_len = 0 is replaced by DEF_SETTLE).
  - Same edge: clears cap_tt, fail_mask, pass and vec_idx, then moves to APPLY.
- APPLY: 1 cycle; the stimulus is stable on the outputs. Loads the settle counter with the latched length, then moves to SETTLE.
- SETTLE: the counter decrements each cycle. Exits to SAMPLE on the cycle it reads 1, so SETTLE lasts exactly N cycles.
- SAMPLE: 1 cycle.
  - cap_tt[vec_idx] <= q_in; fail_mask[vec_idx] <= q_in ^ exp_latched[vec_idx].
  - If vec_idx == 7: go to DONE. Otherwise vec_idx increments and the state goes to APPLY.
  - vec_idx never wraps inside a sweep.
- DONE: 1 cycle.
  - done = 1, pass = (final fail_mask == 0); the final mask includes the bit-7 update from the preceding SAMPLE.
  - Then IDLE. busy deasserts on entry to IDLE.
- Latency: with start accepted at edge k, done is high in the cycle following edge k + 8*(N+2) + 1.
- start while busy is ignored; no queueing.
- abort (any non-IDLE state) moves to IDLE next edge.
  - Clears vec_idx and stimulus to 0.
  - done stays 0 and pass = 0; cap_tt/fail_mask keep their partial contents.
- abort has priority over start in IDLE. start and abort high together in IDLE: stay IDLE.
- exp_tt/settle_len changes during a sweep have no effect.

Decomposition:
- Shared package: state encoding constants (IDLE=0, APPLY=1, SETTLE=2, SAMPLE=3, DONE=4; 3-bit), NUM_VEC = 8, DEF_SETTLE default.
- Sub-module: settle_timer (load, length, expire), a SETTLE_W down-counter with async active-low reset.
- FSM, vector counter and result registers stay in qab_sweep_ctrl.

Test Plan:
- Bench model Q = (A&B)|C, exp_tt = 8'hEA, settle_len = 2, start pulse:
  - vector order 000..111;
  - done after 8*(2+2)+1 edges;
  - cap_tt = 8'hEA, fail_mask = 8'h00, pass = 1.
- Same model, exp_tt = 8'hEB:
  - fail_mask = 8'h01, pass = 0, cap_tt = 8'hEA.
- settle_len = 0:
  - each vector holds DEF_SETTLE+2 = 6 cycles (measured on a_out/b_out/c_out change spacing);
  - result as first scenario.
- Re-pulse start during vec_idx = 3:
  - ignored; sweep completes normally with one done pulse.
- abort during SETTLE of vec_idx = 5:
  - IDLE next edge, outputs 000, no done, pass = 0, cap_tt[4:0] retained.
  - A fresh start then passes.
- rst_n low mid-sweep (vec_idx = 6), asynchronous, between clock edges:
  - all outputs 0 immediately;
  - after release, start yields a full correct sweep.

Source files
------------

// File: rtl/qab_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qab_sweep_ctrl_pkg
// Purpose  : Shared definitions for the truth-table sweep controller: the
//            sequencer state encoding, the number of vectors in a sweep and
//            the settle length used when a zero length is requested.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package qab_sweep_ctrl_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Three stimulus inputs give eight vectors per sweep.
  localparam int c_num_vec    = 8;

  // Settle length substituted when the requested length is zero.
  localparam int c_def_settle = 4;

endpackage : qab_sweep_ctrl_pkg
`default_nettype wire

// File: rtl/qab_sweep_ctrl_settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : qab_sweep_ctrl_settle_timer
// Purpose  : Down-counter that times the settle interval of one vector.
//            A load pulse sets the count to the requested length; the count
//            then decrements once per cycle until it reaches zero. expire is
//            high while the count reads 1, i.e. on the last settle cycle.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset (clears the count)
//            load   - load the counter with length
//            length - settle cycles to time (non-zero)
//            expire - high on the final cycle of the interval
// Revision : 1.0 - initial release
// ============================================================================
module qab_sweep_ctrl_settle_timer #(
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] length,
  output logic                expire
);

  logic [SETTLE_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= length;
    end else if (r_count != '0) begin
      r_count <= r_count - SETTLE_W'(1);
    end
  end

  // Reading 1 means this is the Nth cycle since the load, so the caller
  // leaves its settle state on the following edge.
  assign expire = (r_count == SETTLE_W'(1));

endmodule : qab_sweep_ctrl_settle_timer
`default_nettype wire

// File: rtl/qab_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : qab_sweep_ctrl
// Purpose  : Sweeps a 3-input combinational block through all eight input
//            vectors. Each vector is applied for one cycle, allowed to settle
//            for a programmable number of cycles, then Q is sampled and
//            compared with the expected truth table.
// Ports    : clk, rst_n        - clock / asynchronous active-low reset
//            start, abort      - lab control; start honoured only when idle
//            settle_len        - settle cycles per vector (0 -> DEF_SETTLE)
//            exp_tt            - expected Q indexed by vector
//            q_in              - Q from the function-under-test
//            a_out/b_out/c_out - stimulus, equal to vec_idx[2:0]
//            vec_idx           - current vector index
//            busy, done, pass  - sweep status
//            cap_tt, fail_mask - captured truth table and mismatch bits
// Revision : 1.0 - initial release
// ============================================================================
module qab_sweep_ctrl
  import qab_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE_W   = 8,
  parameter int DEF_SETTLE = c_def_settle
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle_len,
  input  logic [7:0]          exp_tt,
  input  logic                q_in,
  output logic                a_out,
  output logic                b_out,
  output logic                c_out,
  output logic [2:0]          vec_idx,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          cap_tt,
  output logic [7:0]          fail_mask
);

  localparam logic [2:0] c_last_vec = 3'(c_num_vec - 1);

  state_e              r_state;
  state_e              w_next_state;

  logic [7:0]          r_exp;
  logic [SETTLE_W-1:0] r_len;
  logic [2:0]          r_vec_idx;
  logic [7:0]          r_cap_tt;
  logic [7:0]          r_fail_mask;
  logic                r_pass;
  logic                r_done;
  logic                r_busy;

  logic                w_start_ok;
  logic                w_abort_ok;
  logic                w_sample;
  logic                w_load;
  logic                w_expire;

  // --------------------------------------------------------------------------
  // Settle timer
  // --------------------------------------------------------------------------
  qab_sweep_ctrl_settle_timer #(
    .SETTLE_W (SETTLE_W)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .length (r_len),
    .expire (w_expire)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    // abort outranks start even when idle, so both high leaves us idle.
    w_start_ok   = 1'b0;
    w_abort_ok   = 1'b0;
    w_sample     = 1'b0;
    w_load       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_start_ok   = 1'b1;
          w_next_state = ST_APPLY;
        end
      end
      ST_APPLY: begin
        w_load       = 1'b1;
        w_next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_expire) begin
          w_next_state = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        w_sample     = 1'b1;
        w_next_state = (r_vec_idx == c_last_vec) ? ST_DONE : ST_APPLY;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    if (abort && (r_state != ST_IDLE)) begin
      w_abort_ok   = 1'b1;
      w_sample     = 1'b0;
      w_next_state = ST_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Sweep datapath: latched configuration, vector index and results
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp       <= '0;
      r_len       <= '0;
      r_vec_idx   <= '0;
      r_cap_tt    <= '0;
      r_fail_mask <= '0;
      r_pass      <= 1'b0;
    end else if (w_start_ok) begin
      r_exp       <= exp_tt;
      r_len       <= (settle_len == '0) ? SETTLE_W'(DEF_SETTLE) : settle_len;
      r_vec_idx   <= '0;
      r_cap_tt    <= '0;
      r_fail_mask <= '0;
      r_pass      <= 1'b0;
    end else if (w_abort_ok) begin
      // Partial capture and mask are left in place for inspection.
      r_vec_idx   <= '0;
      r_pass      <= 1'b0;
    end else if (w_sample) begin
      r_cap_tt[r_vec_idx]    <= q_in;
      r_fail_mask[r_vec_idx] <= q_in ^ r_exp[r_vec_idx];
      if (r_vec_idx != c_last_vec) begin
        r_vec_idx <= r_vec_idx + 3'd1;
      end
    end else if (r_state == ST_DONE) begin
      // The mask register already holds the bit-7 result written by the
      // preceding SAMPLE, so it is final here.
      r_pass <= (r_fail_mask == 8'h00);
    end
  end

  // --------------------------------------------------------------------------
  // Status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE) && !abort;
      r_busy <= (w_next_state != ST_IDLE);
    end
  end

  assign a_out     = r_vec_idx[2];
  assign b_out     = r_vec_idx[1];
  assign c_out     = r_vec_idx[0];
  assign vec_idx   = r_vec_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign cap_tt    = r_cap_tt;
  assign fail_mask = r_fail_mask;

endmodule : qab_sweep_ctrl
`default_nettype wire

// File: tb/tb_qab_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_qab_sweep_ctrl
// Purpose  : Self-checking bench for qab_sweep_ctrl. The function-under-test
//            is modelled as Q = (A & B) | C, whose truth table is 8'hEA.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qab_sweep_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] settle_len;
  logic [7:0] exp_tt;
  logic       q_in;
  logic       a_out;
  logic       b_out;
  logic       c_out;
  logic [2:0] vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] cap_tt;
  logic [7:0] fail_mask;

  int errors = 0;
  int checks = 0;

  qab_sweep_ctrl #(
    .SETTLE_W   (8),
    .DEF_SETTLE (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .settle_len (settle_len),
    .exp_tt     (exp_tt),
    .q_in       (q_in),
    .a_out      (a_out),
    .b_out      (b_out),
    .c_out      (c_out),
    .vec_idx    (vec_idx),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .cap_tt     (cap_tt),
    .fail_mask  (fail_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function-under-test model.
  always_comb q_in = (a_out & b_out) | c_out;

  typedef struct {
    logic [7:0] exp;
    logic [7:0] len;
    logic [7:0] cap;
    logic [7:0] mask;
    logic       pass;
    int         lat;
    int         hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_abc"},     {29'd0, a_out, b_out, c_out}, 32'd0);
    chk({tag, "_vec"},     {29'd0, vec_idx}, 32'd0);
    chk({tag, "_busy"},    {31'd0, busy}, 32'd0);
    chk({tag, "_done"},    {31'd0, done}, 32'd0);
    chk({tag, "_pass"},    {31'd0, pass}, 32'd0);
    chk({tag, "_cap"},     {24'd0, cap_tt}, 32'd0);
    chk({tag, "_mask"},    {24'd0, fail_mask}, 32'd0);
  endtask

  task automatic wait_vec(input logic [2:0] v, input string tag);
    int n = 0;
    while (vec_idx !== v && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reach_vec"}, {29'd0, vec_idx}, {29'd0, v});
  endtask

  // Full sweep from idle: checks order, spacing, latency and results.
  task automatic run_sweep(input vec_t v, input string tag);
    int       e;
    int       last_change;
    int       order_err;
    int       spacing_err;
    logic [2:0] prev;
    @(negedge clk);
    exp_tt     = v.exp;
    settle_len = v.len;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    // Configuration changes mid-sweep must be ignored.
    exp_tt     = ~v.exp;
    settle_len = 8'd1;
    e           = 0;
    last_change = 0;
    order_err   = 0;
    spacing_err = 0;
    prev        = vec_idx;
    chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    chk({tag, "_vec_start"}, {29'd0, vec_idx}, 32'd0);
    while (done !== 1'b1 && e < 400) begin
      @(negedge clk);
      e++;
      if ({a_out, b_out, c_out} !== vec_idx) order_err++;
      if (vec_idx !== prev) begin
        if (vec_idx !== prev + 3'd1) order_err++;
        if (e - last_change != v.hold) spacing_err++;
        last_change = e;
        prev        = vec_idx;
      end
    end
    chk({tag, "_done"},     {31'd0, done}, 32'd1);
    chk({tag, "_latency"},  e, v.lat);
    chk({tag, "_order"},    order_err, 0);
    chk({tag, "_spacing"},  spacing_err, 0);
    chk({tag, "_last_vec"}, {29'd0, prev}, 32'd7);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_cap"},      {24'd0, cap_tt}, {24'd0, v.cap});
    chk({tag, "_mask"},     {24'd0, fail_mask}, {24'd0, v.mask});
    chk({tag, "_pass"},     {31'd0, pass}, {31'd0, v.pass});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass_hold"},  {31'd0, pass}, {31'd0, v.pass});
  endtask

  vec_t tbl[5];

  initial begin
    int dcount;
    int e;

    // {exp, len, cap, mask, pass, latency 8*(N+2)+1, hold N+2}
    tbl[0] = '{8'hEA, 8'd2, 8'hEA, 8'h00, 1'b1, 33, 4};
    tbl[1] = '{8'hEB, 8'd2, 8'hEA, 8'h01, 1'b0, 33, 4};
    tbl[2] = '{8'hEA, 8'd0, 8'hEA, 8'h00, 1'b1, 49, 6};
    tbl[3] = '{8'h15, 8'd1, 8'hEA, 8'hFF, 1'b0, 25, 3};
    tbl[4] = '{8'h6A, 8'd3, 8'hEA, 8'h80, 1'b0, 41, 5};

    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    settle_len = 8'd0;
    exp_tt     = 8'd0;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_zero("post_reset");

    for (int i = 0; i < 5; i++) begin
      run_sweep(tbl[i], $sformatf("tbl%0d", i));
    end

    // Last table entry failed; make pass=1 so a cleared pass is visible.
    run_sweep(tbl[0], "pre_both");

    // start and abort together while idle: nothing happens.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("both_busy", {31'd0, busy}, 32'd0);
    chk("both_pass", {31'd0, pass}, 32'd1);
    chk("both_vec",  {29'd0, vec_idx}, 32'd7);
    @(negedge clk);
    chk("both_still_idle", {31'd0, busy}, 32'd0);

    // Re-pulse start while sweeping vector 3.
    @(negedge clk);
    exp_tt     = 8'hEA;
    settle_len = 8'd2;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_vec(3'd3, "repulse");
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    dcount = 0;
    e      = 0;
    while (done !== 1'b1 && e < 400) begin
      @(negedge clk);
      e++;
    end
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    chk("repulse_done_count", dcount, 1);
    chk("repulse_cap",  {24'd0, cap_tt}, 32'h0000_00EA);
    chk("repulse_pass", {31'd0, pass}, 32'd1);
    chk("repulse_busy", {31'd0, busy}, 32'd0);

    // Abort during SETTLE of vector 5.
    @(negedge clk);
    exp_tt     = 8'hEA;
    settle_len = 8'd2;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_vec(3'd5, "abort");
    @(negedge clk);   // APPLY -> SETTLE
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_abc",  {29'd0, a_out, b_out, c_out}, 32'd0);
    chk("abort_vec",  {29'd0, vec_idx}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_pass", {31'd0, pass}, 32'd0);
    chk("abort_cap",  {24'd0, cap_tt}, 32'h0000_000A);
    chk("abort_mask", {24'd0, fail_mask}, 32'd0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1 || busy === 1'b1) dcount++;
      @(negedge clk);
    end
    chk("abort_no_done", dcount, 0);
    run_sweep(tbl[0], "after_abort");

    // Asynchronous reset between edges while on vector 6.
    @(negedge clk);
    exp_tt     = 8'hEA;
    settle_len = 8'd2;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_vec(3'd6, "rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(tbl[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_qab_sweep_ctrl
`default_nettype wire
